sprite_blitter: RTL and testbench
=================================

# sprite_blitter

Parametrised, positioned sprite renderer for the VGA pipeline. For each (DrawX, DrawY) it decides whether the pixel lies inside a movable, integer-scaled sprite. It fetches the palette index from a multi-frame sprite ROM, optionally mirrored and auto-animated, and emits registered 4-bit RGB plus an opaque-hit flag to the downstream compositor. It sits between the VGA controller and the colour mux, one instance per on-screen object.

## Interface
- SPRITE_W, 32: sprite width in texels
- SPRITE_H, 32: sprite height in texels
- SCALE_LOG2, 1: on-screen magnification is 2^SCALE_LOG2 (0..3)
- NUM_FRAMES, 4: frames stored back-to-back in the ROM
- ANIM_DIV, 8: video frames per animation step (≥1)
- vga_clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- DrawX, DrawY  in  10 each  current pixel coordinate
- blank  in  1  high = active display region
- sprite_x, sprite_y  in  10 each  top-left screen position
- frame_sel  in  $clog2(NUM_FRAMES)  manual frame index
- anim_en  in  1  1 = auto-advance frames, 0 = use frame_sel
- flip_h  in  1  mirror horizontally
- enable  in  1  0 = sprite invisible
- red, green, blue  out  4 each  registered colour
- hit  out  1  registered: opaque sprite pixel present

## Operation
- Footprint: SPRITE_W<<SCALE_LOG2 by SPRITE_H<<SCALE_LOG2 pixels. inside = enable && DrawX ≥ sprite_x && DrawX < sprite_x + footprint_w, and likewise for Y. Comparisons use 11-bit arithmetic, so sprites near x/y = 1023 do not wrap. Any part of the footprint beyond 639/479 is simply never drawn.
- Texel: col = (DrawX − sprite_x) >> SCALE_LOG2, row = (DrawY − sprite_y) >> SCALE_LOG2. If flip_h, col = SPRITE_W−1−col.
- ROM address = cur_frame·SPRITE_W·SPRITE_H + row·SPRITE_W + col. Width is $clog2(NUM_FRAMES·SPRITE_W·SPRITE_H). Outside the footprint the address is 0, don't-care.
- Palette index 0 is transparent.
- Output rule: hit = blank_d && inside_d && idx≠0. RGB = palette colour when hit, else 0.
- Start of frame (sof): DrawX==0 && DrawY==0, sampled at input.
- cur_frame, sprite_x/y, flip_h and enable are latched only at sof. A mid-frame change never tears the sprite.
- Animation: with anim_en=1, an 8-bit vid counter increments at each sof. When it reaches ANIM_DIV−1 it clears, and cur_frame advances mod NUM_FRAMES (NUM_FRAMES−1 → 0).
- With anim_en=0, cur_frame = frame_sel at sof and the vid counter is held at 0.
- frame_sel ≥ NUM_FRAMES is clamped to NUM_FRAMES−1.
- Reset (async, any time): red/green/blue=0, hit=0, cur_frame=0, vid counter=0, latched position/flip/enable=0, all pipeline valid bits=0. After release, the sprite is invisible until the first sof.

## Timing
- Latency is 3 vga_clk cycles, DrawX/DrawY to red/green/blue/hit:
  - S1 registers the address, inside and blank.
  - S2 is the synchronous ROM read.
  - S3 does the palette lookup plus the output register.
- blank and inside are delayed exactly 3 stages alongside the data.
- Throughput: one pixel per cycle, no stalls, no handshake.
- Latched parameters take effect for the pixel presented at sof. That pixel's output appears 3 cycles later.
- sof and the animation step in the same cycle: the new frame applies from that sof pixel.

## Structure
- Package sprite_pkg holds:
  - typedef coord_t (logic [9:0])
  - typedef rgb4_t
  - constants H_ACTIVE=640, V_ACTIVE=480
  - the transparent index constant TRANSPARENT_IDX=0
- Sub-module sprite_anim_ctrl holds the sof detect, vid counter, cur_frame register, clamp, and latching of position/flip/enable.
- ROM and palette are instantiated as sprite_rom (sync, 1-cycle) and sprite_palette (combinational). Their contents are per instance.

## Test plan
- Reset mid-frame: assert reset_n=0 at DrawX=100. Required: outputs 0 immediately, hit=0. After release, hit stays 0 until the first sof + 3.
- Placement: sprite_x=100, sprite_y=50, SCALE_LOG2=1, enable=1, with a frame whose texel (0,0) is idx 5.
  - Pixel (100,50) → hit=1 with palette[5] three cycles later.
  - Pixels (99,50) and (164,50) → hit=0.
  - Pixels (100,50) and (101,50) give the same texel.
- Flip: flip_h=1. Screen pixel (100,50) returns ROM texel col 31 of row 0.
- Transparency and blank:
  - A texel with idx 0 → hit=0, RGB=0.
  - blank=0 inside the footprint → hit=0, RGB=0.
- Animation: anim_en=1, ANIM_DIV=2, NUM_FRAMES=4. cur_frame sequence over 10 sofs is 0,0,1,1,2,2,3,3,0,0 (wrap).
- Latching and edge:
  - Change sprite_x mid-frame → no effect until the next sof.
  - sprite_x=1020 → no wrap hits at DrawX 0..60.
  - frame_sel=7 with NUM_FRAMES=4 → frame 3.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite renderer.
// Colour, coordinate and palette-index definitions used by every stage.
package sprite_pkg;
    typedef logic [9:0] coord_t;
    typedef logic [3:0] rgb4_t;

    typedef struct packed {
        rgb4_t r;
        rgb4_t g;
        rgb4_t b;
    } rgb_t;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int IDX_W    = 4;

    localparam logic [IDX_W-1:0] TRANSPARENT_IDX = '0;
endpackage

// File: rtl/sprite_anim_ctrl.sv
// Start-of-frame detect, animation counter and per-frame parameter latch.
// Outputs are the values in force for the current pixel, sof included.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int ANIM_DIV   = 8,
    parameter int FW         = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  coord_t        draw_x,
    input  coord_t        draw_y,
    input  coord_t        sprite_x,
    input  coord_t        sprite_y,
    input  logic [FW-1:0] frame_sel,
    input  logic          anim_en,
    input  logic          flip_h,
    input  logic          enable,
    output coord_t        pos_x,
    output coord_t        pos_y,
    output logic [FW-1:0] frame,
    output logic          flip,
    output logic          vis
);
    localparam logic [FW-1:0] LAST     = FW'(NUM_FRAMES - 1);
    localparam logic [7:0]    VID_LAST = 8'(ANIM_DIV - 1);

    coord_t        x_q, x_d, y_q, y_d;
    logic [FW-1:0] frame_q, frame_d, sel_clamped;
    logic [7:0]    vid_q, vid_d;
    logic          flip_q, flip_d, vis_q, vis_d;
    logic          sof;

    assign sof = (draw_x == '0) && (draw_y == '0);

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        frame_d     = frame_q;
        vid_d       = vid_q;
        flip_d      = flip_q;
        vis_d       = vis_q;
        sel_clamped = (32'(frame_sel) >= 32'(NUM_FRAMES)) ? LAST : frame_sel;
        if (!anim_en) vid_d = '0;
        if (sof) begin
            x_d    = sprite_x;
            y_d    = sprite_y;
            flip_d = flip_h;
            vis_d  = enable;
            if (!anim_en) begin
                frame_d = sel_clamped;
            end else if (vid_q == VID_LAST) begin
                vid_d   = '0;
                frame_d = (frame_q == LAST) ? '0 : frame_q + FW'(1);
            end else begin
                vid_d = vid_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
            vid_q   <= '0;
            flip_q  <= 1'b0;
            vis_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            vid_q   <= vid_d;
            flip_q  <= flip_d;
            vis_q   <= vis_d;
        end
    end

    // The sof pixel already sees the freshly latched values.
    assign pos_x = x_d;
    assign pos_y = y_d;
    assign frame = frame_d;
    assign flip  = flip_d;
    assign vis   = vis_d;
endmodule

// File: rtl/sprite_palette.sv
// Combinational 16-entry palette from index to 4-bit RGB.
module sprite_palette
    import sprite_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output rgb_t             rgb
);
    assign rgb.r = idx;
    assign rgb.g = ~idx;
    assign rgb.b = {idx[1:0], idx[3:2]};
endmodule

// File: rtl/sprite_rom.sv
// Synchronous one-cycle sprite texel ROM; content is a per-instance
// procedural pattern keyed by frame, row, column and SALT.
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int AW       = 12,
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int SALT     = 5
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    output logic [IDX_W-1:0] idx
);
    logic [IDX_W-1:0] idx_q, idx_d;
    int               a, t;

    always_comb begin
        a     = 32'(addr);
        t     = (a % SPRITE_W) + 2 * ((a / SPRITE_W) % SPRITE_H)
              + 4 * (a / (SPRITE_W * SPRITE_H)) + SALT;
        idx_d = IDX_W'(t);
    end

    always_ff @(posedge clk) begin
        idx_q <= idx_d;
    end

    assign idx = idx_q;
endmodule

// File: rtl/sprite_blitter.sv
// Positioned, scaled, animated sprite renderer for the VGA pipeline.
// Three-stage pipe: address/inside, ROM read, palette and output register.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32,
    parameter int SCALE_LOG2 = 1,
    parameter int NUM_FRAMES = 4,
    parameter int ANIM_DIV   = 8,
    parameter int ROM_SALT   = 5,
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic          vga_clk,
    input  logic          reset_n,
    input  coord_t        DrawX,
    input  coord_t        DrawY,
    input  logic          blank,
    input  coord_t        sprite_x,
    input  coord_t        sprite_y,
    input  logic [FW-1:0] frame_sel,
    input  logic          anim_en,
    input  logic          flip_h,
    input  logic          enable,
    output rgb4_t         red,
    output rgb4_t         green,
    output rgb4_t         blue,
    output logic          hit
);
    localparam int AW     = $clog2(NUM_FRAMES * SPRITE_W * SPRITE_H);
    localparam int CW     = $clog2(SPRITE_W);
    localparam int RW     = $clog2(SPRITE_H);
    localparam int FOOT_W = SPRITE_W << SCALE_LOG2;
    localparam int FOOT_H = SPRITE_H << SCALE_LOG2;

    coord_t           pos_x, pos_y;
    logic [FW-1:0]    frame;
    logic             flip, vis;
    logic [10:0]      ex, ey, px, py, dx, dy;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             in_d;
    logic [AW-1:0]    addr_d;
    logic [AW-1:0]    s1_addr_q;
    logic             s1_in_q, s1_blank_q, s2_in_q, s2_blank_q;
    logic [IDX_W-1:0] rom_idx;
    rgb_t             pal, out_q, out_d;
    logic             hit_q, hit_d;

    sprite_anim_ctrl #(
        .NUM_FRAMES(NUM_FRAMES),
        .ANIM_DIV  (ANIM_DIV),
        .FW        (FW)
    ) u_ctrl (
        .clk      (vga_clk),
        .rst_n    (reset_n),
        .draw_x   (DrawX),
        .draw_y   (DrawY),
        .sprite_x (sprite_x),
        .sprite_y (sprite_y),
        .frame_sel(frame_sel),
        .anim_en  (anim_en),
        .flip_h   (flip_h),
        .enable   (enable),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .frame    (frame),
        .flip     (flip),
        .vis      (vis)
    );

    // 11-bit compares keep a sprite parked near 1023 from wrapping to 0.
    always_comb begin
        ex     = {1'b0, DrawX};
        ey     = {1'b0, DrawY};
        px     = {1'b0, pos_x};
        py     = {1'b0, pos_y};
        dx     = ex - px;
        dy     = ey - py;
        in_d   = vis
               && (ex >= px) && (ex < px + 11'(FOOT_W))
               && (ey >= py) && (ey < py + 11'(FOOT_H))
               && (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
        col    = CW'(dx >> SCALE_LOG2);
        row    = RW'(dy >> SCALE_LOG2);
        if (flip) col = CW'(SPRITE_W - 1) - col;
        addr_d = '0;
        if (in_d) begin
            addr_d = AW'(frame) * AW'(SPRITE_W * SPRITE_H)
                   + AW'(row) * AW'(SPRITE_W) + AW'(col);
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_addr_q  <= '0;
            s1_in_q    <= 1'b0;
            s1_blank_q <= 1'b0;
            s2_in_q    <= 1'b0;
            s2_blank_q <= 1'b0;
        end else begin
            s1_addr_q  <= addr_d;
            s1_in_q    <= in_d;
            s1_blank_q <= blank;
            s2_in_q    <= s1_in_q;
            s2_blank_q <= s1_blank_q;
        end
    end

    sprite_rom #(
        .AW      (AW),
        .SPRITE_W(SPRITE_W),
        .SPRITE_H(SPRITE_H),
        .SALT    (ROM_SALT)
    ) u_rom (
        .clk (vga_clk),
        .addr(s1_addr_q),
        .idx (rom_idx)
    );

    sprite_palette u_pal (
        .idx(rom_idx),
        .rgb(pal)
    );

    always_comb begin
        hit_d = s2_blank_q && s2_in_q && (rom_idx != TRANSPARENT_IDX);
        out_d = hit_d ? pal : '0;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
            hit_q <= 1'b0;
        end else begin
            out_q <= out_d;
            hit_q <= hit_d;
        end
    end

    assign red   = out_q.r;
    assign green = out_q.g;
    assign blue  = out_q.b;
    assign hit   = hit_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: placement, flip, transparency,
// latching, edge wrap, frame clamp and animation sequencing.
module tb_sprite_blitter;
    import sprite_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    coord_t      DrawX, DrawY, sprite_x, sprite_y;
    logic        blank, anim_en, flip_h, enable;
    logic [1:0]  frame_sel;
    rgb4_t       red, green, blue, red3, green3, blue3;
    logic        hit, hit3;
    logic [12:0] o, o3;
    int          checks = 0;
    int          errors = 0;

    // Expected {hit,r,g,b} for frame 0..3 at texel (0,0).
    logic [12:0] fr_exp [4] = '{13'h15A5, 13'h1966, 13'h1D27, 13'h11E4};
    int          anim_seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    always #5 clk = ~clk;

    sprite_blitter #(.ANIM_DIV(2), .NUM_FRAMES(4)) dut (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .frame_sel(frame_sel), .anim_en(anim_en), .flip_h(flip_h),
        .enable(enable), .red(red), .green(green), .blue(blue), .hit(hit)
    );

    sprite_blitter #(.ANIM_DIV(2), .NUM_FRAMES(3)) dut3 (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .frame_sel(frame_sel), .anim_en(anim_en), .flip_h(flip_h),
        .enable(enable), .red(red3), .green(green3), .blue(blue3),
        .hit(hit3)
    );

    task automatic chk(input string tag, input logic [12:0] obs,
                       input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_px();
        DrawX = 10'd1000;
        DrawY = 10'd1000;
        blank = 1'b0;
    endtask

    task automatic probe(input int x, input int y, input logic b);
        @(negedge clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        @(negedge clk);
        idle_px();
        @(negedge clk);
        @(negedge clk);
        o  = {hit, red, green, blue};
        o3 = {hit3, red3, green3, blue3};
    endtask

    task automatic sof();
        @(negedge clk);
        DrawX = '0;
        DrawY = '0;
        blank = 1'b1;
        @(negedge clk);
        idle_px();
    endtask

    initial begin
        reset_n   = 1'b0;
        idle_px();
        sprite_x  = 10'd100;
        sprite_y  = 10'd50;
        frame_sel = 2'd0;
        anim_en   = 1'b0;
        flip_h    = 1'b0;
        enable    = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", {hit, red, green, blue}, 13'h0);
        reset_n = 1'b1;

        probe(100, 50, 1'b1);
        chk("pre_sof_invisible", o, 13'h0);

        sof();
        probe(100, 50, 1'b1); chk("place_100_50", o, 13'h15A5);
        probe(101, 50, 1'b1); chk("scale_101_50", o, 13'h15A5);
        probe(102, 50, 1'b1); chk("col1_102_50", o, 13'h1699);
        probe(99, 50, 1'b1);  chk("left_99", o, 13'h0);
        probe(163, 50, 1'b1); chk("right_163", o, 13'h14B1);
        probe(164, 50, 1'b1); chk("right_164", o, 13'h0);
        probe(100, 49, 1'b1); chk("top_49", o, 13'h0);
        probe(100, 113, 1'b1); chk("bottom_113", o, 13'h13CC);
        probe(100, 114, 1'b1); chk("bottom_114", o, 13'h0);
        probe(122, 50, 1'b1); chk("transparent", o, 13'h0);
        probe(100, 50, 1'b0); chk("blank_low", o, 13'h0);

        // Latency and reset in the middle of a line.
        @(negedge clk); DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1;
        @(negedge clk); DrawX = 10'd101;
        @(negedge clk); DrawX = 10'd102;
        chk("latency_not_2", {12'h0, hit}, 13'h0);
        @(negedge clk);
        chk("latency_3", {hit, red, green, blue}, 13'h15A5);
        DrawX   = 10'd100;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_frame", {hit, red, green, blue}, 13'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle_px();
        probe(100, 50, 1'b1); chk("post_reset_invisible", o, 13'h0);
        probe(101, 50, 1'b1); chk("post_reset_invisible2", o, 13'h0);
        sof();
        probe(100, 50, 1'b1); chk("post_reset_sof", o, 13'h15A5);

        flip_h = 1'b1;
        probe(100, 50, 1'b1); chk("flip_not_yet", o, 13'h15A5);
        sof();
        probe(100, 50, 1'b1); chk("flip_col31", o, 13'h14B1);
        probe(163, 50, 1'b1); chk("flip_col0", o, 13'h15A5);
        flip_h = 1'b0;
        sof();

        sprite_x = 10'd200;
        probe(100, 50, 1'b1); chk("midframe_old_pos", o, 13'h15A5);
        probe(200, 50, 1'b1); chk("midframe_new_pos", o, 13'h0);
        sof();
        probe(200, 50, 1'b1); chk("next_frame_new", o, 13'h15A5);
        probe(100, 50, 1'b1); chk("next_frame_old", o, 13'h0);

        sprite_x = 10'd1020;
        sof();
        for (int x = 0; x <= 60; x += 20) begin
            probe(x, 50, 1'b1);
            chk($sformatf("no_wrap_x%0d", x), o, 13'h0);
        end

        sprite_x = 10'd100;
        enable   = 1'b0;
        sof();
        probe(100, 50, 1'b1); chk("disabled", o, 13'h0);
        enable = 1'b1;

        frame_sel = 2'd3;
        sof();
        probe(100, 50, 1'b1);
        chk("frame_sel_3", o, fr_exp[3]);
        chk("clamp_nf3", o3, fr_exp[2]);

        frame_sel = 2'd0;
        sof();
        anim_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            probe(100, 50, 1'b1);
            chk($sformatf("anim_sof%0d", k), o, fr_exp[anim_seq[k]]);
            sof();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
